// File: rtl/mem_access_unit.sv
// mem_access_unit
// Load/store unit between a core and a word-wide, big-endian data memory
// with a fixed read latency. Sub-word stores are performed as
// read-modify-write. Illegal-size, misaligned and out-of-range requests
// are answered with a fault and never reach the memory.
//
// Ports
//   mem_Clk, Reset                  clock, synchronous active-high reset
//   req_valid / req_ready           request handshake (ready only in IDLE)
//   req_write, req_size, req_signed request kind: store, size, sign-extend
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid, resp_rdata,
//   resp_fault                      one-cycle response
//   data_memory_a                   word-aligned memory address
//   data_memory_read/_write         one-cycle memory strobes
//   data_memory_out_v               memory write word
//   data_memory_in_v                memory read word
//
// state | meaning
// IDLE  | ready, waiting for a request
// RD    | read strobe for one cycle
// WAIT  | MEM_LATENCY cycles; read word captured on the last edge
// WR    | write strobe for one cycle
// RESP  | response pulse for one cycle
module mem_access_unit #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_LIMIT  = 65536
) (
    input  logic        mem_Clk,
    input  logic        Reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_fault,
    output logic [31:0] data_memory_a,
    output logic        data_memory_read,
    output logic        data_memory_write,
    output logic [31:0] data_memory_out_v,
    input  logic [31:0] data_memory_in_v
);

    typedef enum logic [2:0] {S_IDLE, S_RD, S_WAIT, S_WR, S_RESP} state_t;

    localparam logic [3:0]  WAIT_INIT = 4'(MEM_LATENCY - 1);
    localparam logic [33:0] LIMIT     = 34'(ADDR_LIMIT);

    state_t      state, state_next;
    logic        write_q, signed_q, fault_q;
    logic [1:0]  size_q, offs_q;
    logic [15:0] wdata_q;
    logic [3:0]  wait_cnt;
    logic [31:0] addr_q, out_q, rdata_q;

    logic        accept, req_fault;
    logic [4:0]  byte_sh, half_sh;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_word, merge_word;

    assign accept = req_valid && (state == S_IDLE);

    // Range check uses the last byte of the containing word.
    assign req_fault = (req_size == 2'b11)
                    || ((req_size == 2'b01) && req_addr[0])
                    || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                    || ({2'b00, req_addr[31:2], 2'b11} >= LIMIT);

    // Big-endian lanes: byte o sits (3-o)*8 bits up, a half at o sits (2-o)*8.
    assign byte_sh = {~offs_q, 3'b000};
    assign half_sh = {~offs_q[1], 4'b0000};

    assign load_byte = 8'(data_memory_in_v >> byte_sh);
    assign load_half = 16'(data_memory_in_v >> half_sh);

    always_comb begin
        load_word  = data_memory_in_v;
        merge_word = data_memory_in_v;
        case (size_q)
            2'b00: begin
                load_word  = {{24{signed_q & load_byte[7]}}, load_byte};
                merge_word = (data_memory_in_v & ~(32'h0000_00FF << byte_sh))
                           | ({24'b0, wdata_q[7:0]} << byte_sh);
            end
            2'b01: begin
                load_word  = {{16{signed_q & load_half[15]}}, load_half};
                merge_word = (data_memory_in_v & ~(32'h0000_FFFF << half_sh))
                           | ({16'b0, wdata_q} << half_sh);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (req_valid) begin
                    if (req_fault)
                        state_next = S_RESP;
                    else if (req_write && (req_size == 2'b10))
                        state_next = S_WR;
                    else
                        state_next = S_RD;
                end
            end
            S_RD:   state_next = S_WAIT;
            S_WAIT: begin
                if (wait_cnt == 4'd0)
                    state_next = write_q ? S_WR : S_RESP;
            end
            S_WR:   state_next = S_RESP;
            S_RESP: state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge mem_Clk) begin
        if (Reset) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
            write_q  <= 1'b0;
            signed_q <= 1'b0;
            fault_q  <= 1'b0;
            size_q   <= '0;
            offs_q   <= '0;
            wdata_q  <= '0;
            addr_q   <= '0;
            out_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                write_q  <= req_write;
                signed_q <= req_signed;
                fault_q  <= req_fault;
                size_q   <= req_size;
                offs_q   <= req_addr[1:0];
                wdata_q  <= req_wdata[15:0];
                addr_q   <= {req_addr[31:2], 2'b00};
                out_q    <= req_wdata;
                rdata_q  <= '0;
            end
            if (state == S_RD) begin
                wait_cnt <= WAIT_INIT;
            end else if (state == S_WAIT) begin
                if (wait_cnt != 4'd0)
                    wait_cnt <= wait_cnt - 4'd1;
                else if (write_q)
                    out_q <= merge_word;
                else
                    rdata_q <= load_word;
            end
        end
    end

    assign req_ready         = (state == S_IDLE);
    assign data_memory_read  = (state == S_RD);
    assign data_memory_write = (state == S_WR);
    assign resp_valid        = (state == S_RESP);
    assign resp_fault        = (state == S_RESP) && fault_q;
    assign resp_rdata        = rdata_q;
    assign data_memory_a     = addr_q;
    assign data_memory_out_v = out_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: directed cases with literal expectations,
// then randomized traffic with a per-cycle check against a behavioural model.
module tb_mem_access_unit;

    localparam int LAT   = 2;
    localparam int LIMIT = 32'h0000_FFFC;

    logic        mem_Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [31:0] data_memory_in_v = '0;
    logic        req_ready, resp_valid, resp_fault;
    logic        data_memory_read, data_memory_write;
    logic [31:0] resp_rdata, data_memory_a, data_memory_out_v;

    mem_access_unit #(.MEM_LATENCY(LAT), .ADDR_LIMIT(LIMIT)) dut (
        .mem_Clk(mem_Clk), .Reset(Reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size), .req_signed(req_signed),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .data_memory_a(data_memory_a), .data_memory_read(data_memory_read),
        .data_memory_write(data_memory_write), .data_memory_out_v(data_memory_out_v),
        .data_memory_in_v(data_memory_in_v)
    );

    always #5 mem_Clk = ~mem_Clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: no DUT event within cycle budget at %0t", name, $time);
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] mem [logic [31:0]];

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic bit model_fault(input logic [1:0] s, input logic [31:0] a);
        longint last;
        last = longint'({a[31:2], 2'b00}) + 3;
        return (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'd0)
            || (last >= longint'(LIMIT));
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] s,
                                               input bit sg, input logic [1:0] o);
        logic [7:0]  b [4];
        logic [15:0] h;
        int oi;
        oi = int'(o);
        for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
        if (s == 2'd0) return sg ? {{24{b[oi][7]}}, b[oi]} : {24'b0, b[oi]};
        if (s == 2'd1) begin
            h = {b[oi], b[oi+1]};
            return sg ? {{16{h[15]}}, h} : {16'b0, h};
        end
        return w;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] w, input logic [1:0] s,
                                                input logic [1:0] o, input logic [31:0] d);
        logic [7:0] b [4];
        int oi;
        oi = int'(o);
        for (int i = 0; i < 4; i++) b[i] = w[31 - 8*i -: 8];
        if (s == 2'd0) b[oi] = d[7:0];
        else begin
            b[oi]   = d[15:8];
            b[oi+1] = d[7:0];
        end
        return {b[0], b[1], b[2], b[3]};
    endfunction

    bit          check_en = 0;
    bit          m_active = 0;
    bit          m_rd, m_fault;
    int          m_wr_off, m_lat;
    int          cyc = 0, acc_cyc = 0;
    logic [31:0] m_addr, m_wr_word, m_rdata;
    int          rd_cnt = 0;
    logic [31:0] rd_addr = '0;
    logic [31:0] last_rd_a = '0, last_wr_a = '0, last_wr_word = '0;
    int          n_rd = 0, n_wr = 0, n_resp = 0;

    initial begin : model_p
        int k;
        bit e_ready, e_rd, e_wr, e_resp;
        forever begin
            @(negedge mem_Clk);
            k      = cyc - acc_cyc;
            e_ready = !m_active;
            e_rd   = m_active && m_rd && (k == 1);
            e_wr   = m_active && (m_wr_off != 0) && (k == m_wr_off);
            e_resp = m_active && (k == m_lat);
            if (check_en) begin
                chk("req_ready", req_ready, e_ready);
                chk("data_memory_read", data_memory_read, e_rd);
                chk("data_memory_write", data_memory_write, e_wr);
                chk("resp_valid", resp_valid, e_resp);
                chk("strobe_overlap", data_memory_read & data_memory_write, 0);
                if (e_rd || e_wr || e_resp) chk("data_memory_a", data_memory_a, m_addr);
                if (e_wr) chk("data_memory_out_v", data_memory_out_v, m_wr_word);
                if (e_resp) begin
                    chk("resp_fault", resp_fault, m_fault);
                    chk("resp_rdata", resp_rdata, m_rdata);
                end
            end
            if (data_memory_read === 1'b1) begin n_rd++; last_rd_a = data_memory_a; end
            if (data_memory_write === 1'b1) begin
                n_wr++; last_wr_a = data_memory_a; last_wr_word = data_memory_out_v;
            end
            if (resp_valid === 1'b1) n_resp++;
            if (e_wr) mem[m_addr] = m_wr_word;
            // memory: read word appears only in the cycle LAT after the strobe
            data_memory_in_v = $urandom;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) data_memory_in_v = mem_rd(rd_addr);
            end
            if (data_memory_read === 1'b1) begin rd_cnt = LAT; rd_addr = data_memory_a; end
            // what happens at the coming edge
            if (Reset) m_active = 0;
            else if (e_ready && req_valid) begin
                m_active = 1;
                acc_cyc  = cyc;
                m_addr   = {req_addr[31:2], 2'b00};
                m_fault  = model_fault(req_size, req_addr);
                m_rdata  = '0;
                m_rd     = 0;
                m_wr_off = 0;
                if (m_fault) m_lat = 1;
                else if (!req_write) begin
                    m_rd = 1; m_lat = LAT + 2;
                    m_rdata = model_load(mem_rd(m_addr), req_size, req_signed, req_addr[1:0]);
                end else if (req_size == 2'd2) begin
                    m_wr_off = 1; m_lat = 2; m_wr_word = req_wdata;
                end else begin
                    m_rd = 1; m_wr_off = LAT + 2; m_lat = LAT + 3;
                    m_wr_word = model_merge(mem_rd(m_addr), req_size, req_addr[1:0], req_wdata);
                end
            end else if (e_resp) m_active = 0;
            cyc++;
        end
    end

    // ---------------- driver ----------------
    task automatic step();
        @(posedge mem_Clk);
        #1;
    endtask

    task automatic set_req(input bit w, input logic [1:0] s, input bit sg,
                           input logic [31:0] a, input logic [31:0] d);
        req_write = w; req_size = s; req_signed = sg; req_addr = a; req_wdata = d;
    endtask

    task automatic wait_accept(input bit hold, output int n);
        bit got;
        got = 0;
        n = 0;
        while (!got && n < 64) begin
            @(negedge mem_Clk);
            n++;
            if (req_ready === 1'b1 && !Reset) got = 1;
        end
        if (!got) timeout_fail("accept_timeout");
        step();
        if (!hold) req_valid = 0;
    endtask

    task automatic wait_resp(output logic [31:0] rd, output bit f, output int lat);
        bit got;
        got = 0; lat = 0; rd = '0; f = 0;
        while (!got && lat < 64) begin
            @(negedge mem_Clk);
            lat++;
            if (resp_valid === 1'b1) begin got = 1; rd = resp_rdata; f = resp_fault; end
        end
        if (!got) timeout_fail("resp_timeout");
    endtask

    task automatic txn(input bit w, input logic [1:0] s, input bit sg, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd, output bit f, output int lat);
        int n;
        step();
        set_req(w, s, sg, a, d);
        req_valid = 1;
        wait_accept(0, n);
        wait_resp(rd, f, lat);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          f;
        int          lat, n, rd0, wr0, rs0, r;
        logic [1:0]  fs [4];
        logic [31:0] fa [4];

        Reset = 1;
        @(posedge mem_Clk);
        #1;
        check_en = 1;
        step();
        @(negedge mem_Clk);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_fault", resp_fault, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_mem_a", data_memory_a, 0);
        chk("rst_out_v", data_memory_out_v, 0);
        chk("rst_strobes", {data_memory_read, data_memory_write}, 0);
        step();
        Reset = 0;
        @(negedge mem_Clk);
        chk("ready_after_init_reset", req_ready, 1);

        mem[32'h10] = 32'hDEAD_BEEF;
        txn(0, 2'd2, 0, 32'h10, 0, rd, f, lat);
        chk("word_load_rdata", rd, 32'hDEAD_BEEF);
        chk("word_load_fault", f, 0);
        chk("word_load_lat", lat, LAT + 2);
        chk("word_load_rd_addr", last_rd_a, 32'h10);

        mem[32'h10] = 32'h0000_00F0;
        txn(0, 2'd0, 1, 32'h13, 0, rd, f, lat);
        chk("byte_load_signed", rd, 32'hFFFF_FFF0);
        txn(0, 2'd0, 0, 32'h13, 0, rd, f, lat);
        chk("byte_load_unsigned", rd, 32'h0000_00F0);

        mem[32'h20] = 32'hAABB_CCDD;
        txn(1, 2'd1, 0, 32'h22, 32'h1234, rd, f, lat);
        chk("half_store_word", last_wr_word, 32'hAABB_1234);
        chk("half_store_addr", last_wr_a, 32'h20);
        chk("half_store_rd_addr", last_rd_a, 32'h20);
        chk("half_store_lat", lat, LAT + 3);
        chk("half_store_rdata", rd, 0);
        txn(0, 2'd2, 0, 32'h20, 0, rd, f, lat);
        chk("half_store_readback", rd, 32'hAABB_1234);
        txn(1, 2'd0, 0, 32'h21, 32'h77, rd, f, lat);
        chk("byte_store_word", last_wr_word, 32'hAA77_1234);
        txn(1, 2'd2, 0, 32'h24, 32'hCAFE_F00D, rd, f, lat);
        chk("word_store_word", last_wr_word, 32'hCAFE_F00D);
        chk("word_store_lat", lat, 2);

        mem[32'h40] = 32'h8001_7FFF;
        txn(0, 2'd1, 1, 32'h40, 0, rd, f, lat);
        chk("half_load_signed", rd, 32'hFFFF_8001);
        txn(0, 2'd1, 0, 32'h42, 0, rd, f, lat);
        chk("half_load_unsigned", rd, 32'h0000_7FFF);

        fs[0] = 2'd2; fa[0] = 32'h2;
        fs[1] = 2'd1; fa[1] = 32'h5;
        fs[2] = 2'd3; fa[2] = 32'h8;
        fs[3] = 2'd2; fa[3] = 32'hFFFC;
        for (int i = 0; i < 4; i++) begin
            rd0 = n_rd; wr0 = n_wr;
            txn(0, fs[i], 0, fa[i], 0, rd, f, lat);
            chk($sformatf("fault%0d_flag", i), f, 1);
            chk($sformatf("fault%0d_lat", i), lat, 1);
            chk($sformatf("fault%0d_strobes", i), (n_rd - rd0) + (n_wr - wr0), 0);
        end
        txn(0, 2'd2, 0, 32'hFFF8, 0, rd, f, lat);
        chk("limit_edge_ok", f, 0);

        // reset during WAIT of a byte store
        step();
        set_req(1, 2'd0, 0, 32'h31, 32'h55);
        req_valid = 1;
        wait_accept(0, n);
        step();
        Reset = 1;
        wr0 = n_wr; rs0 = n_resp;
        step();
        Reset = 0;
        @(negedge mem_Clk);
        chk("ready_after_abort", req_ready, 1);
        repeat (LAT + 6) step();
        chk("abort_no_write", n_wr - wr0, 0);
        chk("abort_no_resp", n_resp - rs0, 0);

        // request while in reset is ignored
        step();
        Reset = 1;
        set_req(0, 2'd2, 0, 32'h30, 0);
        req_valid = 1;
        rd0 = n_rd; rs0 = n_resp;
        step();
        req_valid = 0;
        Reset = 0;
        repeat (LAT + 5) step();
        chk("reset_req_ignored", (n_rd - rd0) + (n_resp - rs0), 0);

        // back-to-back with req_valid held high
        step();
        set_req(1, 2'd2, 0, 32'h50, 32'h1111_2222);
        req_valid = 1;
        wait_accept(1, n);
        set_req(1, 2'd2, 0, 32'h54, 32'h3333_4444);
        wait_accept(1, n);
        chk("b2b_store_gap", n, 3);
        set_req(0, 2'd2, 0, 32'h50, 0);
        wait_accept(0, n);
        chk("b2b_load_gap", n, 3);
        wait_resp(rd, f, lat);
        chk("b2b_load_rdata", rd, 32'h1111_2222);

        // randomized traffic
        step();
        for (int t = 0; t < 400; t++) begin
            logic [1:0]  s;
            logic [31:0] a;
            r = $urandom_range(0, 9);
            s = (r < 3) ? 2'd0 : (r < 6) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
            r = $urandom_range(0, 9);
            a = (r < 7) ? 32'($urandom_range(0, 127))
              : (r < 9) ? 32'hFFE0 + 32'($urandom_range(0, 31)) : $urandom;
            set_req(1'($urandom_range(0, 1)), s, 1'($urandom_range(0, 1)), a, $urandom);
            req_valid = 1;
            wait_accept(1, n);
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 0;
                repeat ($urandom_range(0, 6)) step();
            end
            if ($urandom_range(0, 24) == 0) begin
                repeat ($urandom_range(0, 4)) step();
                Reset = 1;
                step();
                Reset = 0;
            end
        end
        req_valid = 0;
        repeat (12) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter MEM_LATENCY, default 1: cycles from the data_memory_read strobe cycle to the cycle in which data_memory_in_v is sampled; legal range 1-15.
REQ-002 Parameter ADDR_LIMIT, default 65536: memory size in bytes; any access touching byte ADDR_LIMIT or above faults.
REQ-003 mem_Clk  in  1  sole clock; all state changes on the rising edge.
REQ-004 Reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  core load/store request present.
REQ-006 req_ready  out  1  unit can accept a request; high only in IDLE.
REQ-007 req_write  in  1  1 = store, 0 = load.
REQ-008 req_size  in  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-009 req_signed  in  1  load result is sign-extended when 1 and zero-extended when 0.
REQ-010 req_addr  in  32  byte address.
REQ-011 req_wdata  in  32  store data, right-justified for byte and half stores.
REQ-012 resp_valid  out  1  one-cycle response pulse.
REQ-013 resp_rdata  out  32  load result, valid with resp_valid; 0 for stores and faults.
REQ-014 resp_fault  out  1  request rejected, valid with resp_valid.
REQ-015 data_memory_a  out  32  word-aligned memory address.
REQ-016 data_memory_read  out  1  memory read strobe.
REQ-017 data_memory_write  out  1  memory write strobe.
REQ-018 data_memory_out_v  out  32  memory write word.
REQ-019 data_memory_in_v  in  32  memory read word.

Function
REQ-020 The memory is big-endian: byte offset o = addr[1:0] maps to word bits [31-8o : 24-8o].
REQ-021 The FSM has five states: IDLE, RD, WAIT, WR and RESP.
REQ-022 A request is accepted on the edge where req_valid=1 and the state is IDLE.
REQ-023 On acceptance, the unit registers all req_* fields and sets data_memory_a = {addr[31:2], 2'b00}.
REQ-024 A request faults if size=11, or a half access has addr[0]=1, or a word access has addr[1:0]!=0, or addr[31:2]*4+3 >= ADDR_LIMIT.
REQ-025 On a fault, the FSM goes IDLE -> RESP with resp_fault=1 and asserts no memory strobe.
REQ-026 Loads follow IDLE -> RD -> WAIT -> RESP.
REQ-027 Word stores follow IDLE -> WR -> RESP.
REQ-028 Byte and half stores follow IDLE -> RD -> WAIT -> WR -> RESP (read-modify-write).
REQ-029 In RD, data_memory_read=1 for exactly one cycle.
REQ-030 WAIT lasts MEM_LATENCY cycles, and data_memory_in_v is captured on the final WAIT edge.
REQ-031 In WR, data_memory_write=1 for exactly one cycle, with data_memory_out_v stable in that cycle.
REQ-032 data_memory_a holds constant from the RD or WR cycle through RESP.
REQ-033 The byte-store merge replaces only byte o of the captured word with wdata[7:0].
REQ-034 The half-store merge replaces bytes o and o+1 with wdata[15:8] and wdata[7:0]; all other bytes are preserved.
REQ-035 Load extraction selects byte o, or the half at o,o+1, then sign- or zero-extends it per req_signed.
REQ-036 A word load returns the captured word unchanged.
REQ-037 RESP lasts one cycle with resp_valid=1, then returns to IDLE; a new request is accepted no earlier than the cycle after resp_valid.
REQ-038 There is no response backpressure; the consumer must take resp_* in the resp_valid cycle.
REQ-039 data_memory_read and data_memory_write are never both 1 in the same cycle.
REQ-040 Latency from the acceptance edge to resp_valid is MEM_LATENCY+2 cycles for loads, 2 for word stores, MEM_LATENCY+3 for sub-word stores and 1 for faults.

Reset
REQ-041 While Reset=1 at an edge, the FSM goes to IDLE and the latency counter clears.
REQ-042 Reset forces resp_valid, resp_fault, data_memory_read and data_memory_write to 0, and resp_rdata, data_memory_a and data_memory_out_v to 0.
REQ-043 req_ready is 1 in the first cycle after Reset deasserts.
REQ-044 A reset mid-operation abandons the request: no response is issued, and no write strobe follows the reset edge.
REQ-045 A request presented while Reset=1 is ignored.

Verification
REQ-046 Word load, MEM_LATENCY=1, addr 0x10, memory word 0xDEADBEEF -> read strobe at 0x10, resp_valid 3 cycles after accept, rdata 0xDEADBEEF, fault 0.
REQ-047 Signed byte load, addr 0x13, word 0x000000F0 -> rdata 0xFFFFFFF0; the same access unsigned -> 0x000000F0.
REQ-048 Half store, addr 0x22, wdata 0x1234, old word 0xAABBCCDD -> read then write at 0x20 with out_v 0xAABB1234; resp 4 cycles after accept.
REQ-049 Faults: word load at 0x02; half load at 0x05; size=11; word load at 0xFFFC with ADDR_LIMIT=0xFFFC -> resp_fault=1 one cycle after accept, no memory strobes.
REQ-050 Reset asserted during WAIT of a byte store -> no write strobe, no resp_valid, req_ready=1 the cycle after reset release.
REQ-051 Back-to-back requests with req_valid held high -> second accepted the cycle after the first resp_valid; the read and write strobes never overlap.
